// File: rtl/execute_cc_stage_pkg.sv
// Shared constants for the Y86-64 execute stage: icodes, ALU function codes,
// jXX/cmovXX condition selectors and condition-code bit positions.
package execute_cc_stage_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALUADD = 2'd0,
    ALUSUB = 2'd1,
    ALUAND = 2'd2,
    ALUXOR = 2'd3
  } alu_fn_e;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  // CC register layout is {ZF, SF, OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/execute_cc_stage_alu.sv
// ALU_wrapper: W-bit add/sub/and/xor with signed-overflow flag.
// Subtraction is a_i - b_i; all arithmetic wraps modulo 2^W.
module ALU_wrapper
  import execute_cc_stage_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   fn_i,
  output logic [W-1:0] result_o,
  output logic         of_o
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  // Overflow only has meaning for add/sub; logical ops report 0
  always_comb begin
    result_o = '0;
    of_o     = 1'b0;
    case (fn_i)
      ALUADD: begin
        result_o = sum;
        of_o     = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      ALUSUB: begin
        result_o = diff;
        of_o     = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
      end
      ALUAND: result_o = a_i & b_i;
      ALUXOR: result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_cc_stage.sv
// Y86-64 execute stage: operand/function select, condition-code register,
// Cnd evaluation and the E->M pipeline register with valid/ready handshake.
module execute_cc_stage
  import execute_cc_stage_pkg::*;
#(
  parameter int W          = 64,
  parameter int STACK_STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   e_icode,
  output logic [W-1:0] e_valE,
  output logic [W-1:0] e_valA,
  output logic         e_cnd,
  output logic [2:0]   e_cc,
  output logic         halted,
  output logic         instr_err
);

  localparam logic [W-1:0] STEP_POS = W'(STACK_STEP);
  localparam logic [W-1:0] STEP_NEG = '0 - W'(STACK_STEP);

  logic         out_valid_q, e_cnd_q, halted_q, instr_err_q;
  logic [3:0]   e_icode_q;
  logic [W-1:0] e_valE_q, e_valA_q;
  logic [2:0]   cc_q, cc_d;

  logic [W-1:0] aluA, aluB, aluRes;
  logic [1:0]   aluFn;
  logic         aluOf, badFn, cnd, accept;

  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic lt;
    lt = cc[CC_SF] ^ cc[CC_OF];
    case (fn)
      C_YES:   return 1'b1;
      C_LE:    return lt | cc[CC_ZF];
      C_L:     return lt;
      C_E:     return cc[CC_ZF];
      C_NE:    return !cc[CC_ZF];
      C_GE:    return !lt;
      C_G:     return !lt && !cc[CC_ZF];
      default: return 1'b0;
    endcase
  endfunction

  // Unlisted and invalid icodes leave both operands at zero so valE is 0
  always_comb begin
    aluA  = '0;
    aluB  = '0;
    aluFn = ALUADD;
    badFn = 1'b0;
    case (icode)
      IRRMOVQ: aluA = valA;
      IIRMOVQ: aluA = valC;
      IRMMOVQ, IMRMOVQ: begin
        aluA = valC;
        aluB = valB;
      end
      IOPQ: begin
        aluA = valA;
        aluB = valB;
        if (ifun > 4'd3) badFn = 1'b1;
        else             aluFn = ifun[1:0];
      end
      ICALL, IPUSHQ: begin
        aluA = STEP_NEG;
        aluB = valB;
      end
      IRET, IPOPQ: begin
        aluA = STEP_POS;
        aluB = valB;
      end
      default: ;
    endcase
  end

  ALU_wrapper #(.W(W)) u_alu (
    .a_i      (aluB),
    .b_i      (aluA),
    .fn_i     (aluFn),
    .result_o (aluRes),
    .of_o     (aluOf)
  );

  assign cc_d[CC_ZF] = (aluRes == '0);
  assign cc_d[CC_SF] = aluRes[W-1];
  assign cc_d[CC_OF] = aluOf && (aluFn == ALUADD || aluFn == ALUSUB);

  assign cnd      = (icode == IRRMOVQ || icode == IJXX) ? cond_eval(ifun, cc_q) : 1'b0;
  assign in_ready = !halted_q && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      e_icode_q   <= '0;
      e_valE_q    <= '0;
      e_valA_q    <= '0;
      e_cnd_q     <= 1'b0;
      halted_q    <= 1'b0;
      instr_err_q <= 1'b0;
      cc_q        <= CC_RESET;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      e_icode_q   <= icode;
      e_valE_q    <= aluRes;
      e_valA_q    <= valA;
      e_cnd_q     <= cnd;
      if (icode == IHALT) halted_q <= 1'b1;
      if (icode > IPOPQ || badFn) instr_err_q <= 1'b1;
      if (icode == IOPQ) cc_q <= cc_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign e_icode   = e_icode_q;
  assign e_valE    = e_valE_q;
  assign e_valA    = e_valA_q;
  assign e_cnd     = e_cnd_q;
  assign e_cc      = cc_q;
  assign halted    = halted_q;
  assign instr_err = instr_err_q;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Self-checking bench for execute_cc_stage: a cycle-level reference model of the
// stage plus directed Y86 instruction vectors with literal expected results.
module tb_execute_cc_stage;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  icode, ifun, e_icode;
  logic [63:0] valA, valB, valC, e_valE, e_valA;
  logic        e_cnd, halted, instr_err;
  logic [2:0]  e_cc;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 0;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic        cnd;
    logic        zf;
    logic        sf;
    logic        of;
    logic        halted;
    logic        err;
  } model_t;

  model_t m;

  execute_cc_stage #(.W(64), .STACK_STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA),
    .valB      (valB),
    .valC      (valC),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .e_icode   (e_icode),
    .e_valE    (e_valE),
    .e_valA    (e_valA),
    .e_cnd     (e_cnd),
    .e_cc      (e_cc),
    .halted    (halted),
    .instr_err (instr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Y86 semantics written directly: what one clock edge does to the stage
  function automatic model_t modelStep(model_t s, logic r, logic inV, logic outR,
                                       logic [3:0] ic, logic [3:0] fn,
                                       logic [63:0] a, logic [63:0] b, logic [63:0] c);
    model_t n;
    logic [63:0] res;
    logic ovf, lt;
    n = s;
    if (r) begin
      n = '0;
      n.zf = 1'b1;
      return n;
    end
    if (inV && !s.halted && (!s.valid || outR)) begin
      res = 64'd0;
      ovf = 1'b0;
      case (ic)
        4'd2: res = a;
        4'd3: res = c;
        4'd4, 4'd5: res = b + c;
        4'd6: begin
          case (fn)
            4'd1: begin
              res = b - a;
              ovf = (b[63] != a[63]) && (res[63] != b[63]);
            end
            4'd2: res = b & a;
            4'd3: res = b ^ a;
            default: begin
              res = b + a;
              ovf = (b[63] == a[63]) && (res[63] != b[63]);
            end
          endcase
        end
        4'd8, 4'd10: res = b - 64'd8;
        4'd9, 4'd11: res = b + 64'd8;
        default: res = 64'd0;
      endcase
      lt = s.sf ^ s.of;
      n.cnd = 1'b0;
      if (ic == 4'd2 || ic == 4'd7) begin
        case (fn)
          4'd0: n.cnd = 1'b1;
          4'd1: n.cnd = lt || s.zf;
          4'd2: n.cnd = lt;
          4'd3: n.cnd = s.zf;
          4'd4: n.cnd = !s.zf;
          4'd5: n.cnd = !lt;
          4'd6: n.cnd = !lt && !s.zf;
          default: n.cnd = 1'b0;
        endcase
      end
      n.valid = 1'b1;
      n.icode = ic;
      n.valE  = res;
      n.valA  = a;
      if (ic == 4'd0) n.halted = 1'b1;
      if (ic > 4'd11 || (ic == 4'd6 && fn > 4'd3)) n.err = 1'b1;
      if (ic == 4'd6) begin
        n.zf = (res == 64'd0);
        n.sf = res[63];
        n.of = ovf;
      end
    end else if (outR) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one instruction (caller is just after a rising edge) and holds it until accepted
  task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bit done;
    done     = 1'b0;
    icode    = ic;
    ifun     = fn;
    valA     = a;
    valB     = b;
    valC     = c;
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("accept_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      m = modelStep(m, rst, in_valid, out_ready, icode, ifun, valA, valB, valC);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("in_ready",  64'(in_ready),  64'(!m.halted && (!m.valid || out_ready)));
        checkOutput("out_valid", 64'(out_valid), 64'(m.valid));
        checkOutput("e_cc",      64'(e_cc),      64'({m.zf, m.sf, m.of}));
        checkOutput("halted",    64'(halted),    64'(m.halted));
        checkOutput("instr_err", 64'(instr_err), 64'(m.err));
        if (m.valid) begin
          checkOutput("e_icode", 64'(e_icode), 64'(m.icode));
          checkOutput("e_valE",  e_valE,       m.valE);
          checkOutput("e_valA",  e_valA,       m.valA);
          checkOutput("e_cnd",   64'(e_cnd),   64'(m.cnd));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h1; ifun = 4'h0; valA = 64'd0; valB = 64'd0; valC = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_cc",        64'(e_cc),      64'h4);
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);

    applyStimulus(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
    checkOutput("subq_eq_valE", e_valE,     64'd0);
    checkOutput("subq_eq_cc",   64'(e_cc),  64'h4);
    applyStimulus(4'h7, 4'h3, 64'd0, 64'd0, 64'h40);
    checkOutput("je_cnd",       64'(e_cnd), 64'd1);

    applyStimulus(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    checkOutput("addq_ovf_valE", e_valE,    64'h8000_0000_0000_0000);
    checkOutput("addq_ovf_cc",   64'(e_cc), 64'h3);

    applyStimulus(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    checkOutput("pushq_valE", e_valE,    64'hF8);
    applyStimulus(4'hB, 4'h0, 64'd0, 64'h100, 64'd0);
    checkOutput("popq_valE",  e_valE,    64'h108);
    checkOutput("popq_cc",    64'(e_cc), 64'h3);

    applyStimulus(4'h6, 4'h1, 64'd7, 64'd3, 64'd0);
    checkOutput("subq_neg_valE", e_valE,    64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("subq_neg_cc",   64'(e_cc), 64'h2);
    applyStimulus(4'h2, 4'h2, 64'h1234, 64'd99, 64'd0);
    checkOutput("cmovl_valE", e_valE,     64'h1234);
    checkOutput("cmovl_cnd",  64'(e_cnd), 64'd1);
    applyStimulus(4'h2, 4'h5, 64'h1234, 64'd99, 64'd0);
    checkOutput("cmovge_cnd", 64'(e_cnd), 64'd0);

    // Reset while a result is still waiting for the memory stage
    out_ready = 1'b0;
    checkOutput("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_cc",        64'(e_cc),      64'h4);
    checkOutput("midrst_halted",    64'(halted),    64'd0);
    checkOutput("midrst_in_ready",  64'(in_ready),  64'd1);

    applyStimulus(4'h6, 4'h0, 64'd1, 64'd2, 64'd0);
    checkOutput("bp_first_valE", e_valE,    64'd3);
    checkOutput("bp_first_cc",   64'(e_cc), 64'h0);
    fork
      applyStimulus(4'h6, 4'h3, 64'd7, 64'd7, 64'd0);
      begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp_hold_valE",   e_valE,        64'd3);
        checkOutput("bp_hold_ready",  64'(in_ready), 64'd0);
        checkOutput("bp_hold_cc",     64'(e_cc),     64'h0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    checkOutput("bp_second_valE", e_valE,    64'd0);
    checkOutput("bp_second_cc",   64'(e_cc), 64'h4);

    applyStimulus(4'hE, 4'h0, 64'h55, 64'h66, 64'h77);
    checkOutput("badicode_valE", e_valE,         64'd0);
    checkOutput("badicode_valA", e_valA,         64'h55);
    checkOutput("badicode_err",  64'(instr_err), 64'd1);

    applyStimulus(4'h0, 4'h0, 64'h9, 64'h0, 64'h0);
    checkOutput("halt_flag",  64'(halted),  64'd1);
    checkOutput("halt_icode", 64'(e_icode), 64'd0);
    icode    = 4'h1;
    ifun     = 4'h0;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("halt_in_ready",  64'(in_ready),  64'd0);
    checkOutput("halt_drained",   64'(out_valid), 64'd0);
    in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/execute_cc_stage.md
Name: execute_cc_stage

Overview:
- Y86-64 execute stage: selects ALU operands and function from the decoded instruction and drives the existing ALU_wrapper.
- Holds the condition-code register (ZF, SF, OF), evaluates Cnd for jXX/cmovXX, and registers results into the E->M pipeline register.
- Sits between decode/register-read and memory; valid/ready handshake on both sides.

Parameters:
- W, 64, datapath width (valA, valB, valC, valE).
- STACK_STEP, 8, stack pointer increment/decrement for call/ret/push/pop.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- icode  in  4  Y86 icode (0x0..0xB).
- ifun  in  4  Y86 ifun.
- valA  in  W  register rA value.
- valB  in  W  register rB value.
- valC  in  W  immediate/displacement.
- out_valid  out  1  E->M register holds a result.
- out_ready  in  1  memory stage consumes.
- e_icode  out  4  registered icode.
- e_valE  out  W  registered ALU result.
- e_valA  out  W  registered valA passthrough.
- e_cnd  out  1  registered condition result.
- e_cc  out  3  current CC register {ZF,SF,OF}.
- halted  out  1  HALT has been accepted.
- instr_err  out  1  sticky; an icode > 0xB was accepted.

Behaviour:
- Reset (synchronous, clk edge with rst=1): out_valid=0, e_icode=0, e_valE=0, e_valA=0, e_cnd=0, halted=0, instr_err=0, CC={ZF=1,SF=0,OF=0}. Overrides any transfer in the same cycle, including a transfer in flight.
- Handshake:
  - in_ready = !halted && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Latency: 1 cycle from accept to out_valid=1.
  - Output holds stable while out_valid && !out_ready.
  - If out_ready is high with no accept, out_valid clears next cycle.
- Operand select (combinational):
  - aluA: valA for rrmovq(2)/OPq(6); valC for irmovq(3)/rmmovq(4)/mrmovq(5); -STACK_STEP for call(8)/pushq(A); +STACK_STEP for ret(9)/popq(B); 0 otherwise.
  - aluB: valB for 4/5/6/8/9/A/B; 0 for 2/3/others.
- ALU function: ifun[1:0] for OPq (0 add, 1 sub, 2 and, 3 xor); add otherwise. OPq with ifun > 3 sets instr_err and is treated as add.
- Sub-module port order: ALU first operand = aluB, second operand = aluA, so subq yields valB - valA. Arithmetic wraps modulo 2^W.
- CC update: only on accept with icode=6.
  - ZF = (result == 0).
  - SF = result[W-1].
  - OF = ALU OF output; forced 0 for and/xor.
  - No other icode changes CC.
- Cnd: evaluated from the CC value before this instruction's update. ifun 0 = 1; 1 le = (SF^OF)|ZF; 2 l = SF^OF; 3 e = ZF; 4 ne = !ZF; 5 ge = !(SF^OF); 6 g = !(SF^OF)&!ZF; ifun > 6 gives 0. e_cnd is valid for icode 2 and 7 and is 0 for all other icodes.
- HALT (icode 0): when accepted, it passes to the output and halted=1 from the next cycle. in_ready stays 0 until reset. Output still drains normally.
- Invalid icode (> 0xB): accepted and passed through with valE=0; instr_err latches 1.
- Back-to-back OPq instructions: the second sees the first's CC update (single CC register, updated at accept).

Decomposition:
- Shared package: icode constants (IHALT..IPOPQ), ALU function codes (ALUADD/SUB/AND/XOR), condition codes (C_YES..C_G), CC bit indices.
- Sub-module: existing ALU_wrapper, instantiated once. The cond_eval function lives inside this module; no separate module.

Test Plan:
- Reset with rst=1 mid-stream (out_valid=1) -> next edge out_valid=0, e_cc=3'b100, halted=0, in_ready=1.
- OPq subq (ifun=1) valA=5, valB=5, then jXX ifun=3 -> first e_valE=0, e_cc=3'b100; jump e_cnd=1. Then addq valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> e_valE=0x8000_0000_0000_0000, e_cc=3'b011.
- pushq valB=0x100 -> e_valE=0xF8; popq valB=0x100 -> e_valE=0x108; CC unchanged across both.
- cmovl (icode 2, ifun 2) after subq valB=3, valA=7 -> valE=valA passthrough, e_cnd=1; cmovge -> e_cnd=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, CC not updated twice; release -> exactly one update per instruction.
- halt accepted -> halted=1, in_ready=0 while in_valid=1 persists; icode 0xE -> instr_err=1 (before halt test, or after reset).
